// File: rtl/stream_demux_n_if.sv
// Bundle for the 1-to-N demux: producer side (s_*) plus N consumer channels (m_*).
// A beat moves on a side exactly when valid & ready are both high on a rising clk edge;
// a holder of valid keeps data/last stable until that edge, and ready never depends on valid.
interface stream_demux_n_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
);
    logic [WIDTH-1:0]       s_data;
    logic [SEL_W-1:0]       s_sel;
    logic                   s_last;
    logic                   s_valid;
    logic                   s_ready;
    logic [N_OUT*WIDTH-1:0] m_data;
    logic [N_OUT-1:0]       m_last;
    logic [N_OUT-1:0]       m_valid;
    logic [N_OUT-1:0]       m_ready;
    logic                   err_sel;

    modport master (
        output s_data, s_sel, s_last, s_valid, m_ready,
        input  s_ready, m_data, m_last, m_valid, err_sel
    );

    modport slave (
        input  s_data, s_sel, s_last, s_valid, m_ready,
        output s_ready, m_data, m_last, m_valid, err_sel
    );
endinterface

// File: rtl/stream_demux_n.sv
// 1-to-N stream demultiplexer: one output register per channel, optional per-packet route lock.
// o_state exposes the packet FSM (0 = IDLE, 1 = LOCK).
module stream_demux_n #(
    parameter int WIDTH    = 8,
    parameter int N_OUT    = 4,
    parameter int PKT_MODE = 1,
    localparam int SEL_W   = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_demux_n_if.slave        bus,
    output logic                   o_state
);
    typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_W-1:0]       r_lock_sel;
    logic [N_OUT*WIDTH-1:0] r_data;
    logic [N_OUT-1:0]       r_last;
    logic [N_OUT-1:0]       r_valid;
    logic                   r_err;

    logic [SEL_W-1:0]       w_tgt;
    logic                   w_in_range;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_load_lock;
    logic [N_OUT-1:0]       w_load;

    // Target comes from the lock only while a packet is open; the select is never wrapped.
    always_comb begin
        w_tgt      = (PKT_MODE != 0 && r_state == S_LOCK) ? r_lock_sel : bus.s_sel;
        w_in_range = (32'(w_tgt) < N_OUT);
        if (rst)
            w_ready = 1'b0;
        else if (!w_in_range)
            w_ready = 1'b1;
        else
            w_ready = !r_valid[w_tgt] || bus.m_ready[w_tgt];
        w_accept = bus.s_valid && w_ready;
        for (int i = 0; i < N_OUT; i++)
            w_load[i] = w_accept && w_in_range && (w_tgt == SEL_W'(i));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_lock = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (PKT_MODE != 0 && w_accept && !bus.s_last) begin
                    w_state_nxt = S_LOCK;
                    w_load_lock = 1'b1;
                end
            end
            S_LOCK: begin
                if (w_accept && bus.s_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lock_sel <= '0;
            r_data     <= '0;
            r_last     <= '0;
            r_valid    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_lock)
                r_lock_sel <= bus.s_sel;
            r_err <= w_accept && !w_in_range;
            for (int i = 0; i < N_OUT; i++) begin
                if (w_load[i]) begin
                    r_data[i*WIDTH +: WIDTH] <= bus.s_data;
                    r_last[i]                <= bus.s_last;
                    r_valid[i]               <= 1'b1;
                end else if (bus.m_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.s_ready = w_ready;
    assign bus.m_data  = r_data;
    assign bus.m_last  = r_last;
    assign bus.m_valid = r_valid;
    assign bus.err_sel = r_err;
    assign o_state     = (r_state == S_LOCK);
endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: per-beat instance (N_OUT=4) and packet instance (N_OUT=3),
// both checked every cycle against a queue-free channel model plus literal expectations.
module tb_stream_demux_n;
    logic clk = 1'b0;
    logic rst;
    logic st_a, st_b;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    stream_demux_n_if #(.WIDTH(8), .N_OUT(4)) if_a ();
    stream_demux_n_if #(.WIDTH(8), .N_OUT(3)) if_b ();

    stream_demux_n #(.WIDTH(8), .N_OUT(4), .PKT_MODE(0)) u_a (
        .clk(clk), .rst(rst), .bus(if_a.slave), .o_state(st_a));
    stream_demux_n #(.WIDTH(8), .N_OUT(3), .PKT_MODE(1)) u_b (
        .clk(clk), .rst(rst), .bus(if_b.slave), .o_state(st_b));

    // model: per-channel register contents, error pulse, packet lock
    int         n_out [2] = '{4, 3};
    bit         pkt   [2] = '{1'b0, 1'b1};
    bit         mv    [2][4];
    logic [7:0] md    [2][4];
    bit         ml    [2][4];
    bit         merr  [2];
    bit         mlock [2];
    int         mlsel [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic get_in(input int d, output bit v, output int sel, output bit last,
                          output logic [7:0] data, output logic [3:0] rdy);
        if (d == 0) begin
            v = if_a.s_valid; sel = int'(if_a.s_sel); last = if_a.s_last;
            data = if_a.s_data; rdy = 4'(if_a.m_ready);
        end else begin
            v = if_b.s_valid; sel = int'(if_b.s_sel); last = if_b.s_last;
            data = if_b.s_data; rdy = 4'(if_b.m_ready);
        end
    endtask

    function automatic int target(input int d, input int sel);
        return (pkt[d] && mlock[d]) ? mlsel[d] : sel;
    endfunction

    function automatic bit exp_rdy(input int d, input int sel, input logic [3:0] rdy);
        int t;
        t = target(d, sel);
        if (rst) return 1'b0;
        if (t >= n_out[d]) return 1'b1;
        return !mv[d][t] || rdy[t];
    endfunction

    always @(posedge clk) begin
        bit v, last, acc;
        int sel, t;
        logic [7:0] data;
        logic [3:0] rdy;
        for (int d = 0; d < 2; d++) begin
            get_in(d, v, sel, last, data, rdy);
            if (rst) begin
                for (int c = 0; c < 4; c++) begin mv[d][c] = 0; md[d][c] = 0; ml[d][c] = 0; end
                merr[d] = 0; mlock[d] = 0; mlsel[d] = 0;
            end else begin
                t   = target(d, sel);
                acc = v && exp_rdy(d, sel, rdy);
                for (int c = 0; c < n_out[d]; c++)
                    if (mv[d][c] && rdy[c]) mv[d][c] = 0;
                merr[d] = 0;
                if (acc) begin
                    if (t < n_out[d]) begin
                        mv[d][t] = 1; md[d][t] = data; ml[d][t] = last;
                    end else begin
                        merr[d] = 1;
                    end
                    if (pkt[d] && !mlock[d] && !last) begin
                        mlock[d] = 1; mlsel[d] = sel;
                    end else if (pkt[d] && mlock[d] && last) begin
                        mlock[d] = 0;
                    end
                end
            end
        end
    end

    // compare process, away from the active edge
    always @(negedge clk) begin
        bit v, last;
        int sel;
        logic [7:0] data;
        logic [3:0] rdy;
        logic [31:0] dvec, lvec, evec;
        logic [31:0] act_v, act_d, act_l, act_r, act_e, act_s;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                get_in(d, v, sel, last, data, rdy);
                if (d == 0) begin
                    act_v = 32'(if_a.m_valid); act_d = 32'(if_a.m_data); act_l = 32'(if_a.m_last);
                    act_r = 32'(if_a.s_ready); act_e = 32'(if_a.err_sel); act_s = 32'(st_a);
                end else begin
                    act_v = 32'(if_b.m_valid); act_d = 32'(if_b.m_data); act_l = 32'(if_b.m_last);
                    act_r = 32'(if_b.s_ready); act_e = 32'(if_b.err_sel); act_s = 32'(st_b);
                end
                evec = 0;
                for (int c = 0; c < n_out[d]; c++) evec[c] = mv[d][c];
                check($sformatf("dut%0d s_ready", d), act_r, 32'(exp_rdy(d, sel, rdy)));
                check($sformatf("dut%0d m_valid", d), act_v, evec);
                check($sformatf("dut%0d err_sel", d), act_e, 32'(merr[d]));
                check($sformatf("dut%0d state", d), act_s, 32'(mlock[d]));
                for (int c = 0; c < n_out[d]; c++) begin
                    if (mv[d][c]) begin
                        dvec = 32'(act_d[c*8 +: 8]);
                        lvec = 32'(act_l[c]);
                        check($sformatf("dut%0d ch%0d data", d, c), dvec, 32'(md[d][c]));
                        check($sformatf("dut%0d ch%0d last", d, c), lvec, 32'(ml[d][c]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit v, input int sel, input logic [7:0] data, input bit last);
        if_a.s_valid = v; if_a.s_sel = 2'(sel); if_a.s_data = data; if_a.s_last = last;
    endtask

    task automatic drive_b(input bit v, input int sel, input logic [7:0] data, input bit last);
        if_b.s_valid = v; if_b.s_sel = 2'(sel); if_b.s_data = data; if_b.s_last = last;
    endtask

    initial begin
        logic [31:0] dw;
        rst = 1'b1;
        drive_a(1, 0, 8'h00, 0);
        drive_b(1, 0, 8'h00, 0);
        if_a.m_ready = 4'hF;
        if_b.m_ready = 3'h7;

        // reset held two cycles with s_valid high
        tick();
        chk_en = 1'b1;
        #1;
        check("rst s_ready a", 32'(if_a.s_ready), 0);
        check("rst s_ready b", 32'(if_b.s_ready), 0);
        tick();
        check("rst m_valid a", 32'(if_a.m_valid), 0);
        check("rst m_valid b", 32'(if_b.m_valid), 0);
        check("rst err_sel b", 32'(if_b.err_sel), 0);
        rst = 1'b0;
        drive_a(0, 0, 8'h00, 0);
        drive_b(0, 0, 8'h00, 0);
        tick();

        // per-beat routing to all four channels
        for (int k = 0; k < 4; k++) begin
            drive_a(1, k, 8'hA0 + 8'(k), 0);
            #1;
            check($sformatf("route s_ready %0d", k), 32'(if_a.s_ready), 1);
            tick();
            dw = 32'(if_a.m_data);
            check($sformatf("route valid %0d", k), 32'(if_a.m_valid), 32'(1) << k);
            check($sformatf("route data %0d", k), 32'(dw[k*8 +: 8]), 32'(8'hA0 + 8'(k)));
        end
        drive_a(0, 0, 8'h00, 0);
        tick();
        check("route drained", 32'(if_a.m_valid), 0);

        // backpressure on channel 2
        if_a.m_ready = 4'b1011;
        drive_a(1, 2, 8'h11, 0);
        tick();
        drive_a(1, 2, 8'h22, 0);
        #1;
        check("bp s_ready low", 32'(if_a.s_ready), 0);
        tick();
        check("bp hold data", 32'(if_a.m_data[23:16]), 32'h11);
        check("bp hold valid", 32'(if_a.m_valid), 32'b0100);
        if_a.m_ready = 4'hF;
        #1;
        check("bp s_ready high", 32'(if_a.s_ready), 1);
        tick();
        check("bp new data", 32'(if_a.m_data[23:16]), 32'h22);
        check("bp new valid", 32'(if_a.m_valid), 32'b0100);
        drive_a(0, 0, 8'h00, 0);
        tick();

        // channel independence: 0 stalled, beat to 3 still flows
        if_a.m_ready = 4'b1110;
        drive_a(1, 0, 8'h55, 0);
        tick();
        drive_a(1, 3, 8'h66, 0);
        #1;
        check("indep s_ready", 32'(if_a.s_ready), 1);
        tick();
        check("indep valid", 32'(if_a.m_valid), 32'b1001);
        check("indep ch3", 32'(if_a.m_data[31:24]), 32'h66);
        check("indep ch0", 32'(if_a.m_data[7:0]), 32'h55);
        drive_a(0, 0, 8'h00, 0);
        if_a.m_ready = 4'hF;
        tick();
        tick();

        // packet lock: select on later beats is ignored
        drive_b(1, 1, 8'hB0, 0);
        tick();
        check("pkt b0 data", 32'(if_b.m_data[15:8]), 32'hB0);
        check("pkt locked", 32'(st_b), 1);
        drive_b(1, 3, 8'hB1, 0);
        tick();
        check("pkt b1 data", 32'(if_b.m_data[15:8]), 32'hB1);
        check("pkt b1 valid", 32'(if_b.m_valid), 32'b010);
        check("pkt b1 err", 32'(if_b.err_sel), 0);
        drive_b(1, 3, 8'hB2, 1);
        tick();
        check("pkt b2 data", 32'(if_b.m_data[15:8]), 32'hB2);
        check("pkt b2 last", 32'(if_b.m_last[1]), 1);
        check("pkt idle", 32'(st_b), 0);
        drive_b(0, 0, 8'h00, 0);
        tick();

        // out-of-range single beat is dropped with one error pulse
        drive_b(1, 3, 8'hC0, 1);
        #1;
        check("oor s_ready", 32'(if_b.s_ready), 1);
        tick();
        check("oor err", 32'(if_b.err_sel), 1);
        check("oor no valid", 32'(if_b.m_valid), 0);
        drive_b(0, 0, 8'h00, 0);
        tick();
        check("oor err once", 32'(if_b.err_sel), 0);

        // out-of-range lock drops the whole packet, then reset mid-packet
        drive_b(1, 3, 8'hD0, 0);
        tick();
        check("oor lock err", 32'(if_b.err_sel), 1);
        check("oor lock state", 32'(st_b), 1);
        drive_b(1, 0, 8'hD1, 0);
        tick();
        check("oor lock drop err", 32'(if_b.err_sel), 1);
        check("oor lock drop valid", 32'(if_b.m_valid), 0);
        drive_b(0, 0, 8'h00, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst state", 32'(st_b), 0);
        check("midrst err", 32'(if_b.err_sel), 0);
        drive_b(1, 0, 8'hE0, 1);
        tick();
        check("midrst route valid", 32'(if_b.m_valid), 32'b001);
        check("midrst route data", 32'(if_b.m_data[7:0]), 32'hE0);
        check("midrst route err", 32'(if_b.err_sel), 0);
        drive_b(0, 0, 8'h00, 0);
        tick();
        tick();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
